debug_reg_scan_ctrl: RTL and testbench

- Avalon-MM slave controller that sequences the 5-bit debug register-select bus in the debug module.
- Idle: drives a host-programmed manual select.
- Scan: sweeps the select from FIRST to LAST, waits a programmable settle time per index, and captures the 32-bit debug data into an internal sample buffer.
- Host reads the buffer afterwards; optional completion interrupt.

---
 rtl/debug_scan_pkg.sv | 41 ++++
 rtl/debug_scan_buf.sv | 27 ++
 rtl/debug_reg_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_debug_reg_scan_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_scan_pkg.sv
// Shared definitions for the debug register-select scan controller:
// FSM state encoding, register offsets and CTRL/STAT bit positions.
package debug_scan_pkg;

   localparam int SEL_W_DEF  = 5;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } scan_state_e;

   // Register offsets
   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_RANGE    = 3'd1;
   localparam logic [2:0] ADDR_SETTLE   = 3'd2;
   localparam logic [2:0] ADDR_MANUAL   = 3'd3;
   localparam logic [2:0] ADDR_STAT     = 3'd4;
   localparam logic [2:0] ADDR_BUF_ADDR = 3'd5;
   localparam logic [2:0] ADDR_BUF_DATA = 3'd6;
   localparam logic [2:0] ADDR_CUR      = 3'd7;

   // CTRL write bits
   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_CONT   = 2;
   localparam int CTRL_IRQ_EN = 3;

   // CTRL read / STAT W1C bits
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ERR     = 2;
   localparam int STAT_IRQ_EN  = 3;
   localparam int STAT_ABORTED = 4;

   // LSB of the LAST field in RANGE
   localparam int RANGE_LAST_LSB = 8;

endpackage

// File: rtl/debug_scan_buf.sv
// Sample buffer: 2**SEL_W x DATA_W, one synchronous write port and one
// asynchronous read port.
module debug_scan_buf
   import debug_scan_pkg::*;
#(
   parameter int SEL_W  = SEL_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [SEL_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [SEL_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**SEL_W];

   // Capture one sample per write strobe.
   // NOTE: the array has no reset; clearing it would turn the RAM into flops.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_reg_scan_ctrl.sv
// Avalon-MM controller for the debug register-select bus. Idle drives the
// host's manual select; a scan sweeps FIRST..LAST, settles, and captures
// dbg_data into the sample buffer.
// Optional macro DEBUG_SCAN_IRQ_EN: enables the IRQ_EN bit and irq output.
module debug_reg_scan_ctrl
   import debug_scan_pkg::*;
#(
   parameter int         SEL_W      = SEL_W_DEF,
   parameter int         DATA_W     = DATA_W_DEF,
   parameter logic [7:0] SETTLE_RST = 8'd3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [SEL_W-1:0]  reg_sel,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              busy,
   output logic              irq
);

   scan_state_e       state_q;
   logic [SEL_W-1:0]  cur_q, first_q, last_q, manual_q, buf_addr_q;
   logic [7:0]        settle_q, cnt_q;
   logic              cont_q, done_q, err_q, aborted_q, irq_en_q;
   logic [DATA_W-1:0] buf_rdata;
   logic              wr, wr_ctrl, wr_stat, start_w, abort_w, buf_we;
   logic              unused_wdata;

   assign wr      = chipselect & ~write_n;
   assign wr_ctrl = wr && (address == ADDR_CTRL);
   assign wr_stat = wr && (address == ADDR_STAT);
   assign start_w = wr_ctrl & writedata[CTRL_START];
   assign abort_w = wr_ctrl & writedata[CTRL_ABORT];
   assign unused_wdata = ^writedata[31:13];

   assign busy    = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
   assign reg_sel = (state_q == ST_IDLE) ? manual_q : cur_q;
   assign buf_we  = (state_q == ST_CAPTURE) && !abort_w;

   // Host-programmable configuration registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         first_q    <= '0;
         last_q     <= '0;
         settle_q   <= SETTLE_RST;
         manual_q   <= '0;
         buf_addr_q <= '0;
         cont_q     <= 1'b0;
      end else if (wr) begin
         case (address)
            ADDR_CTRL:     cont_q     <= writedata[CTRL_CONT];
            ADDR_RANGE: begin
               first_q <= writedata[SEL_W-1:0];
               last_q  <= writedata[RANGE_LAST_LSB +: SEL_W];
            end
            ADDR_SETTLE:   settle_q   <= writedata[7:0];
            ADDR_MANUAL:   manual_q   <= writedata[SEL_W-1:0];
            ADDR_BUF_ADDR: buf_addr_q <= writedata[SEL_W-1:0];
            default: ;
         endcase
      end
   end

`ifdef DEBUG_SCAN_IRQ_EN
   // Interrupt enable, written with every CTRL access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        irq_en_q <= 1'b0;
      else if (wr_ctrl) irq_en_q <= writedata[CTRL_IRQ_EN];
   end
   assign irq = done_q & irq_en_q;
`else
   assign irq_en_q = 1'b0;
   assign irq      = 1'b0;
`endif

   // Scan sequencer with its status flags; W1C clears come first so an FSM
   // update on the same edge takes priority.
   // NOTE: non-blocking assignments keep every flop reading pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         if (wr_stat) begin
            if (writedata[STAT_DONE])    done_q    <= 1'b0;
            if (writedata[STAT_ERR])     err_q     <= 1'b0;
            if (writedata[STAT_ABORTED]) aborted_q <= 1'b0;
         end
         if (abort_w && (state_q != ST_IDLE)) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_w && !abort_w) begin
                     if (first_q <= last_q) begin
                        cur_q     <= first_q;
                        cnt_q     <= settle_q;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        aborted_q <= 1'b0;
                        state_q   <= ST_SETTLE;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               ST_SETTLE: begin
                  if (cnt_q == 8'd0) state_q <= ST_CAPTURE;
                  else               cnt_q   <= cnt_q - 8'd1;
               end
               ST_CAPTURE: begin
                  if (cur_q != last_q) begin
                     cur_q   <= cur_q + 1'b1;
                     cnt_q   <= settle_q;
                     state_q <= ST_SETTLE;
                  end else if (cont_q) begin
                     cur_q   <= first_q;
                     cnt_q   <= settle_q;
                     done_q  <= 1'b1;
                     state_q <= ST_SETTLE;
                  end else begin
                     state_q <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   debug_scan_buf #(
      .SEL_W  (SEL_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (cur_q),
      .wdata_i (dbg_data),
      .raddr_i (buf_addr_q),
      .rdata_o (buf_rdata)
   );

   // Combinational read mux.
   // NOTE: the default assignment first keeps this block latch-free.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL: begin
            readdata[STAT_BUSY]    = busy;
            readdata[STAT_DONE]    = done_q;
            readdata[STAT_ERR]     = err_q;
            readdata[STAT_IRQ_EN]  = irq_en_q;
            readdata[STAT_ABORTED] = aborted_q;
         end
         ADDR_RANGE: begin
            readdata[SEL_W-1:0]              = first_q;
            readdata[RANGE_LAST_LSB +: SEL_W] = last_q;
         end
         ADDR_SETTLE:   readdata[7:0]        = settle_q;
         ADDR_MANUAL:   readdata[SEL_W-1:0]  = manual_q;
         ADDR_STAT: begin
            readdata[STAT_DONE]    = done_q;
            readdata[STAT_ERR]     = err_q;
            readdata[STAT_ABORTED] = aborted_q;
         end
         ADDR_BUF_ADDR: readdata[SEL_W-1:0]  = buf_addr_q;
         ADDR_BUF_DATA: readdata[DATA_W-1:0] = buf_rdata;
         ADDR_CUR:      readdata[SEL_W-1:0]  = cur_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_debug_reg_scan_ctrl.sv
// Self-checking bench for debug_reg_scan_ctrl. Expected values are queued
// when stimulus is driven and popped when the DUT output is sampled.
module tb_debug_reg_scan_ctrl;

   localparam logic [2:0] A_CTRL = 3'd0, A_RANGE = 3'd1, A_SETTLE = 3'd2,
                          A_MANUAL = 3'd3, A_STAT = 3'd4, A_BADDR = 3'd5,
                          A_BDATA = 3'd6, A_CUR = 3'd7;
`ifdef DEBUG_SCAN_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata, readdata, dbg_data;
   logic [4:0]  reg_sel;
   logic        busy, irq;
   logic [15:0] dbg_tag;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];

   // Debug module model: value depends on the selected index plus a tag.
   assign dbg_data = {dbg_tag, 16'h00A0 + {11'd0, reg_sel}};

   always #5 clk = ~clk;

   debug_reg_scan_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .reg_sel    (reg_sel),
      .dbg_data   (dbg_data),
      .busy       (busy),
      .irq        (irq)
   );

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      #1;
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0; dbg_tag = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if ({busy, irq, reg_sel} !== 7'd0) begin
         $display("FAIL reset_outputs busy/irq/reg_sel got %b want 0", {busy, irq, reg_sel});
         miscompares++;
      end
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd !== 32'd0) begin
         $display("FAIL reset_ctrl got %h want 00000000", rd); miscompares++;
      end
      bus_read(A_SETTLE, rd);
      vectors++;
      if (rd !== 32'd3) begin
         $display("FAIL reset_settle got %h want 00000003", rd); miscompares++;
      end
      bus_write(A_MANUAL, 32'd5);
      vectors++;
      if (reg_sel !== 5'd5 || busy !== 1'b0) begin
         $display("FAIL manual_sel reg_sel=%0d busy=%b want 5/0", reg_sel, busy);
         miscompares++;
      end
   endtask

   task automatic test_scan();
      logic [31:0] rd, ex;
      bus_write(A_RANGE, 32'h0000_0402);
      bus_write(A_SETTLE, 32'd1);
      for (int i = 0; i < 9; i++) exp_q.push_back({26'd0, 1'b1, 5'(2 + i / 3)});
      bus_write(A_CTRL, 32'h1);
      for (int i = 0; i < 11; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (i < 9) begin
            ex = exp_q.pop_front();
            vectors++;
            if ({26'd0, busy, reg_sel} !== ex) begin
               $display("FAIL scan_cycle%0d busy/sel got %h want %h", i, {26'd0, busy, reg_sel}, ex);
               miscompares++;
            end
         end else if (i == 9) begin
            vectors++;
            if (busy !== 1'b0) begin
               $display("FAIL scan_busy_end got %b want 0", busy); miscompares++;
            end
         end else begin
            vectors++;
            if (reg_sel !== 5'd5) begin
               $display("FAIL scan_manual_back got %0d want 5", reg_sel); miscompares++;
            end
         end
      end
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd !== 32'h2) begin
         $display("FAIL scan_done_ctrl got %h want 00000002", rd); miscompares++;
      end
      for (int a = 2; a <= 4; a++) exp_q.push_back(32'hA0 + a);
      for (int a = 2; a <= 4; a++) begin
         bus_write(A_BADDR, a);
         bus_read(A_BDATA, rd);
         ex = exp_q.pop_front();
         vectors++;
         if (rd !== ex) begin
            $display("FAIL scan_buf%0d got %h want %h", a, rd, ex); miscompares++;
         end
      end
   endtask

   task automatic test_range_err();
      logic [31:0] rd, ex;
      bus_write(A_RANGE, 32'h0000_0307);
      bus_write(A_CTRL, 32'h1);
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd[2] !== 1'b1 || rd[0] !== 1'b0 || busy !== 1'b0 || reg_sel !== 5'd5) begin
         $display("FAIL err_set ctrl=%h busy=%b sel=%0d want err=1 busy=0 sel=5", rd, busy, reg_sel);
         miscompares++;
      end
      for (int a = 2; a <= 4; a++) exp_q.push_back(32'hA0 + a);
      for (int a = 2; a <= 4; a++) begin
         bus_write(A_BADDR, a);
         bus_read(A_BDATA, rd);
         ex = exp_q.pop_front();
         vectors++;
         if (rd !== ex) begin
            $display("FAIL err_buf%0d got %h want %h", a, rd, ex); miscompares++;
         end
      end
      bus_write(A_STAT, 32'h4);
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd[2] !== 1'b0) begin
         $display("FAIL err_w1c got %b want 0", rd[2]); miscompares++;
      end
   endtask

   task automatic test_abort();
      logic [31:0] rd, ex;
      bus_write(A_STAT, 32'h16);
      bus_write(A_RANGE, 32'h0000_1F00);
      bus_write(A_SETTLE, 32'd0);
      bus_write(A_CTRL, 32'h1);
      repeat (10) @(posedge clk);
      bus_write(A_CTRL, 32'h2);
      vectors++;
      if (busy !== 1'b0) begin
         $display("FAIL abort_busy got %b want 0", busy); miscompares++;
      end
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd !== 32'h10) begin
         $display("FAIL abort_ctrl got %h want 00000010", rd); miscompares++;
      end
      bus_read(A_CUR, rd);
      vectors++;
      if (rd !== 32'd5) begin
         $display("FAIL abort_cur got %0d want 5", rd); miscompares++;
      end
      for (int a = 0; a <= 4; a++) exp_q.push_back(32'hA0 + a);
      for (int a = 0; a <= 4; a++) begin
         bus_write(A_BADDR, a);
         bus_read(A_BDATA, rd);
         ex = exp_q.pop_front();
         vectors++;
         if (rd !== ex) begin
            $display("FAIL abort_buf%0d got %h want %h", a, rd, ex); miscompares++;
         end
      end
   endtask

   task automatic test_cont();
      logic [31:0] rd, ex;
      bus_write(A_RANGE, 32'h0000_0909);
      bus_write(A_SETTLE, 32'd2);
      bus_write(A_BADDR, 32'd9);
      bus_write(A_CTRL, 32'h5);
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd[1] !== 1'b0 || rd[0] !== 1'b1) begin
         $display("FAIL cont_start ctrl got %h want busy=1 done=0", rd); miscompares++;
      end
      for (int k = 0; k < 4; k++) begin
         dbg_tag = 16'(k + 1);
         exp_q.push_back({16'(k + 1), 16'h00A9});
         repeat (4) @(posedge clk);
         bus_read(A_BDATA, rd);
         ex = exp_q.pop_front();
         vectors++;
         if (rd !== ex || reg_sel !== 5'd9 || busy !== 1'b1) begin
            $display("FAIL cont_pass%0d buf=%h sel=%0d busy=%b want %h/9/1", k, rd, reg_sel, busy, ex);
            miscompares++;
         end
         if (k == 0) begin
            bus_read(A_CTRL, rd);
            vectors++;
            if (rd[1] !== 1'b1) begin
               $display("FAIL cont_done got %b want 1", rd[1]); miscompares++;
            end
         end
      end
      dbg_tag = '0;
      bus_write(A_CTRL, 32'h2);
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd !== 32'h12 || busy !== 1'b0) begin
         $display("FAIL cont_abort ctrl=%h busy=%b want 00000012/0", rd, busy); miscompares++;
      end
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      int budget;
      bus_write(A_STAT, 32'h16);
      bus_write(A_CTRL, 32'h9);
      vectors++;
      if (irq !== 1'b0) begin
         $display("FAIL irq_start got %b want 0", irq); miscompares++;
      end
      budget = 50;
      while (busy === 1'b1 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      vectors++;
      if (budget == 0) begin
         $display("FAIL irq_scan_timeout busy=%b want 0", busy); miscompares++;
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (irq !== IRQ_ON) begin
         $display("FAIL irq_rise got %b want %b", irq, IRQ_ON); miscompares++;
      end
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd !== {28'd0, IRQ_ON, 3'b010}) begin
         $display("FAIL irq_ctrl got %h want %h", rd, {28'd0, IRQ_ON, 3'b010}); miscompares++;
      end
      bus_write(A_STAT, 32'h2);
      bus_read(A_CTRL, rd);
      vectors++;
      if (irq !== 1'b0 || rd[1] !== 1'b0) begin
         $display("FAIL irq_clear irq=%b done=%b want 0/0", irq, rd[1]); miscompares++;
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [31:0] rd;
      bus_write(A_CTRL, 32'h1);
      @(posedge clk);
      #3;
      vectors++;
      if (busy !== 1'b1) begin
         $display("FAIL midrst_pre busy got %b want 1", busy); miscompares++;
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || reg_sel !== 5'd0) begin
         $display("FAIL midrst_async busy=%b sel=%0d want 0/0", busy, reg_sel); miscompares++;
      end
      @(negedge clk);
      reset = 1'b0;
      bus_read(A_SETTLE, rd);
      vectors++;
      if (rd !== 32'd3) begin
         $display("FAIL midrst_settle got %h want 00000003", rd); miscompares++;
      end
      bus_read(A_CTRL, rd);
      vectors++;
      if (rd !== 32'd0) begin
         $display("FAIL midrst_ctrl got %h want 00000000", rd); miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_range_err();
      test_abort();
      test_cont();
      test_irq();
      test_reset_mid_scan();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
